// File: rtl/l2_evict_writeback.sv
// l2_evict_writeback: one-entry victim buffer that drains an evicted dirty L2
// line to memory as an ascending burst of s_beat-wide beats, and offers a
// combinational line-address snoop against the buffered copy while it is held.
module l2_evict_writeback #(
   parameter int s_offset  = 5,
   parameter int s_line    = 8 * 2**s_offset,
   parameter int s_beat    = 64,
   parameter int num_beats = s_line / s_beat
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              evict_req,
   input  logic [31:0]       evict_addr,
   input  logic [s_line-1:0] evict_line,
   output logic              evict_ready,
   output logic              evict_done,
   output logic              mem_write,
   output logic [31:0]       mem_address,
   output logic [s_beat-1:0] mem_wdata,
   input  logic              mem_resp,
   input  logic [31:0]       snoop_addr,
   output logic              snoop_hit,
   output logic [s_line-1:0] snoop_line
);

   localparam int beat_w = (num_beats > 1) ? $clog2(num_beats) : 1;
   localparam int tag_w  = 32 - s_offset;
   localparam logic [beat_w-1:0] last_beat = beat_w'(num_beats - 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BURST = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t            state;
   logic              valid;
   logic [beat_w-1:0] beat;
   logic [tag_w-1:0]  buf_tag;
   logic [s_line-1:0] buf_line;

   // Beat view of the buffered line; beat 0 is the least significant slice.
   logic [s_beat-1:0] beat_data [num_beats];

   for (genvar i = 0; i < num_beats; i++) begin : g_beat
      assign beat_data[i] = buf_line[i*s_beat +: s_beat];
   end

   // Offset bits of both addresses play no part: the buffer works on whole lines.
   logic unused_offset_bits;
   assign unused_offset_bits = ^{evict_addr[s_offset-1:0], snoop_addr[s_offset-1:0]};

   // Capture on accept, step through the beats on each memory acknowledge,
   // then pulse done for one cycle before reopening the buffer.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         valid       <= 1'b0;
         beat        <= '0;
         buf_tag     <= '0;
         buf_line    <= '0;
         evict_ready <= 1'b1;
         evict_done  <= 1'b0;
         mem_write   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               evict_done <= 1'b0;
               if (evict_req) begin
                  buf_tag     <= evict_addr[31:s_offset];
                  buf_line    <= evict_line;
                  valid       <= 1'b1;
                  beat        <= '0;
                  evict_ready <= 1'b0;
                  mem_write   <= 1'b1;
                  state       <= BURST;
               end
            end
            BURST: begin
               if (mem_resp) begin
                  if (beat == last_beat) begin
                     valid      <= 1'b0;
                     mem_write  <= 1'b0;
                     evict_done <= 1'b1;
                     state      <= DONE;
                  end else begin
                     beat <= beat + beat_w'(1);
                  end
               end
            end
            DONE: begin
               evict_done  <= 1'b0;
               evict_ready <= 1'b1;
               beat        <= '0;
               state       <= IDLE;
            end
            default: begin
               state       <= IDLE;
               valid       <= 1'b0;
               beat        <= '0;
               evict_ready <= 1'b1;
               evict_done  <= 1'b0;
               mem_write   <= 1'b0;
            end
         endcase
      end
   end

   assign mem_address = {buf_tag, {s_offset{1'b0}}};
   assign mem_wdata   = beat_data[beat];
   assign snoop_hit   = valid && (snoop_addr[31:s_offset] == buf_tag);
   assign snoop_line  = buf_line;

endmodule

// File: tb/tb_l2_evict_writeback.sv
// Testbench for l2_evict_writeback: directed and randomized evictions checked
// against a beat-count model of the burst derived from the line contents.
module tb_l2_evict_writeback;

   localparam int NB = 4;

   logic         clk = 1'b0;
   logic         rst;
   logic         evict_req;
   logic [31:0]  evict_addr;
   logic [255:0] evict_line;
   logic         evict_ready;
   logic         evict_done;
   logic         mem_write;
   logic [31:0]  mem_address;
   logic [63:0]  mem_wdata;
   logic         mem_resp;
   logic [31:0]  snoop_addr;
   logic         snoop_hit;
   logic [255:0] snoop_line;

   int checks = 0;
   int errors = 0;
   logic [31:0] last_addr = 32'h0;

   l2_evict_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .evict_req   (evict_req),
      .evict_addr  (evict_addr),
      .evict_line  (evict_line),
      .evict_ready (evict_ready),
      .evict_done  (evict_done),
      .mem_write   (mem_write),
      .mem_address (mem_address),
      .mem_wdata   (mem_wdata),
      .mem_resp    (mem_resp),
      .snoop_addr  (snoop_addr),
      .snoop_hit   (snoop_hit),
      .snoop_line  (snoop_line)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] line_base(input logic [31:0] a);
      return {a[31:5], 5'b0};
   endfunction

   // Idle-state expectations: buffer open, nothing on the memory side.
   task automatic chk_idle(input string tag);
      chk({tag, "_ready"}, evict_ready, 1);
      chk({tag, "_done"}, evict_done, 0);
      chk({tag, "_write"}, mem_write, 0);
      chk({tag, "_addr"}, mem_address, last_addr);
      chk({tag, "_hit"}, snoop_hit, 0);
   endtask

   // One full eviction: per beat the memory waits a random number of cycles
   // in [smin,smax] before acknowledging. Expected beat = line slice at the
   // number of beats acknowledged so far.
   task automatic do_evict(input logic [31:0] addr, input logic [255:0] line,
                           input int smin, input int smax, input bit req_mid,
                           input int snoop_mode);
      int acked, wait_cnt, cur_stall, sum_stall, cyc;
      bit exp_hit;
      cyc = 0;
      while (evict_ready !== 1'b1 && cyc < 50) begin
         tick();
         cyc++;
      end
      chk("ready_before_accept", evict_ready, 1);
      evict_req  = 1'b1;
      evict_addr = addr;
      evict_line = line;
      mem_resp   = 1'b0;
      tick();
      evict_req = req_mid;
      if (req_mid) begin
         evict_addr = ~addr;
         evict_line = ~line;
      end
      acked = 0;
      wait_cnt = 0;
      cyc = 1;
      cur_stall = $urandom_range(smax, smin);
      sum_stall = cur_stall;
      while (acked < NB && cyc < 1000) begin
         if (snoop_mode == 1)
            snoop_addr = cyc[0] ? 32'h0000_123C : 32'h0000_1240;
         else if ($urandom_range(1, 0) == 1)
            snoop_addr = {addr[31:5], 5'($urandom)};
         else
            snoop_addr = $urandom;
         #1;
         exp_hit = (snoop_addr[31:5] == addr[31:5]);
         chk("burst_write", mem_write, 1);
         chk("burst_ready", evict_ready, 0);
         chk("burst_done", evict_done, 0);
         chk("burst_addr", mem_address, line_base(addr));
         chk("burst_wdata", mem_wdata, line[64*acked +: 64]);
         chk("burst_snoop_hit", snoop_hit, exp_hit);
         if (exp_hit) chk("burst_snoop_line", snoop_line, line);
         if (wait_cnt == cur_stall) begin
            mem_resp = 1'b1;
            acked++;
            wait_cnt = 0;
            if (acked < NB) begin
               cur_stall = $urandom_range(smax, smin);
               sum_stall += cur_stall;
            end
         end else begin
            mem_resp = 1'b0;
            wait_cnt++;
         end
         tick();
         cyc++;
      end
      chk("burst_bound", acked, NB);
      last_addr  = line_base(addr);
      evict_req  = 1'b0;
      mem_resp   = 1'($urandom);
      snoop_addr = addr;
      #1;
      chk("done_pulse", evict_done, 1);
      chk("done_write", mem_write, 0);
      chk("done_ready", evict_ready, 0);
      chk("done_snoop_hit", snoop_hit, 0);
      chk("done_cycle", cyc, sum_stall + NB + 1);
      tick();
      mem_resp = 1'b0;
      chk_idle("after_done");
   endtask

   logic [255:0] bytes_line;
   logic [255:0] rline;
   logic [31:0]  raddr;

   initial begin
      rst        = 1'b1;
      evict_req  = 1'b0;
      evict_addr = 32'h0;
      evict_line = '0;
      mem_resp   = 1'b0;
      snoop_addr = 32'h0;
      for (int i = 0; i < 32; i++) bytes_line[8*i +: 8] = 8'(i);

      // Reset state
      tick();
      tick();
      chk_idle("reset");
      chk("reset_wdata", mem_wdata, 0);
      chk("reset_snoop_line", snoop_line, 0);
      rst = 1'b0;
      tick();

      // Spurious mem_resp in IDLE
      for (int i = 0; i < 6; i++) begin
         mem_resp = i[0];
         tick();
         chk_idle("spurious_idle");
      end
      mem_resp = 1'b0;

      // Single eviction, ack one cycle after each beat appears
      do_evict(32'h0000_1234, bytes_line, 1, 1, 1'b0, 0);
      chk("single_addr", mem_address, 32'h0000_1220);

      // Back-to-back acknowledges
      do_evict(32'h0000_1234, bytes_line, 0, 0, 1'b0, 0);

      // Stalled memory with an ignored mid-burst request
      do_evict(32'hABCD_EF17, ~bytes_line, 10, 10, 1'b1, 0);

      // Snoop hit then miss during the burst
      do_evict(32'h0000_1234, bytes_line, 2, 2, 1'b0, 1);

      // Reset after beat 1 is acknowledged
      evict_req  = 1'b1;
      evict_addr = 32'h0000_5678;
      evict_line = bytes_line;
      tick();
      evict_req = 1'b0;
      mem_resp  = 1'b1;
      chk("rst_test_beat0", mem_wdata, bytes_line[63:0]);
      tick();
      chk("rst_test_beat1", mem_wdata, bytes_line[127:64]);
      tick();
      chk("rst_test_beat2", mem_wdata, bytes_line[191:128]);
      mem_resp   = 1'b0;
      snoop_addr = 32'h0000_5678;
      rst        = 1'b1;
      #1;
      last_addr = 32'h0;
      chk_idle("mid_reset");
      tick();
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_idle("post_reset");
      end
      do_evict(32'h0000_5678, ~bytes_line, 0, 1, 1'b0, 0);

      // Randomized evictions
      for (int n = 0; n < 10; n++) begin
         raddr = $urandom;
         for (int w = 0; w < 8; w++) rline[32*w +: 32] = $urandom;
         do_evict(raddr, rline, 0, $urandom_range(3, 0), 1'($urandom), 0);
         for (int i = 0; i < int'($urandom_range(2, 0)); i++) begin
            mem_resp = 1'($urandom);
            tick();
            chk_idle("rand_gap");
         end
         mem_resp = 1'b0;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
